dmem_responder: RTL and testbench

Memory-side responder for the toy CPU's data-memory port. It accepts single-word read/write requests from the CPU over a valid/ready request channel and executes them against an internal 16-bit-wide store after a configurable number of wait states. It returns the result on a valid/ready response channel. It sits between the CPU datapath (address mux, write-data mux, RegA load path) and the data storage, replacing the zero-latency data memory with a handshaked, multi-cycle one.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width of the storage array; a single-word store still needs one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - data storage, synchronous write, asynchronous read, no reset
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; the caller only raises we for in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked multi-cycle data-memory responder
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_was_write,
    output logic              rsp_err
);

    localparam int IDX_W = idx_w(DEPTH);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_range;
    logic              commit;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign req_ready = (state == IDLE) && !rst;

    // Zero-extend so the compare stays unsigned even when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, lat_addr} < (ADDR_W + 1)'(DEPTH));

    // Reset wins over a coinciding commit, so an abandoned write never lands.
    assign commit = (state == WAIT) && (cnt == '0) && !rst;
    assign mem_we = commit && lat_we && in_range;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (lat_addr[IDX_W-1:0]),
        .wdata (lat_wdata),
        .rdata (mem_rdata)
    );

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: the counter is loaded with WAIT_CYCLES so the commit lands
    // WAIT_CYCLES+1 edges after acceptance.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_W'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture; inputs are ignored once the request is accepted.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Response registers: loaded on commit, valid dropped on handshake, payload held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_was_write <= 1'b0;
            rsp_err       <= 1'b0;
        end else if (commit) begin
            rsp_valid     <= 1'b1;
            rsp_was_write <= lat_we;
            rsp_err       <= !in_range;
            rsp_rdata     <= (in_range && !lat_we) ? mem_rdata : '0;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

    typedef struct {
        int          dut;
        logic [15:0] rdata;
        logic        ww;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [11:0] req_addr [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_was_write [2];
    logic        rsp_err [2];

    exp_t sbq [$];
    exp_t cur [2];
    logic chk [2];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_was_write(rsp_was_write[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_was_write(rsp_was_write[1]), .rsp_err(rsp_err[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each new response, then checks the payload holds.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                chk[i] = 1'b0;
            end else begin
                if (rsp_valid[i] && !chk[i]) begin
                    if (sbq.size() == 0 || sbq[0].dut != i) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp dut=%0d actual=valid required=no_response", i);
                        cur[i].rdata = rsp_rdata[i];
                        cur[i].ww    = rsp_was_write[i];
                        cur[i].err   = rsp_err[i];
                    end else begin
                        cur[i] = sbq.pop_front();
                        check($sformatf("rsp_rdata_d%0d", i), 32'(rsp_rdata[i]), 32'(cur[i].rdata));
                        check($sformatf("rsp_was_write_d%0d", i), 32'(rsp_was_write[i]), 32'(cur[i].ww));
                        check($sformatf("rsp_err_d%0d", i), 32'(rsp_err[i]), 32'(cur[i].err));
                        check($sformatf("rsp_latency_d%0d", i), cyc, cur[i].cyc);
                    end
                end else if (rsp_valid[i]) begin
                    check($sformatf("hold_rdata_d%0d", i), 32'(rsp_rdata[i]), 32'(cur[i].rdata));
                    check($sformatf("hold_err_d%0d", i), 32'(rsp_err[i]), 32'(cur[i].err));
                end
                chk[i] = rsp_valid[i];
            end
        end
    end

    task automatic issue(input int i, input logic we, input logic [11:0] a, input logic [15:0] d,
                         input logic [15:0] er, input logic ee, input bit push);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
        for (int k = 0; k < 50; k++) begin
            if (req_ready[i]) begin
                if (push) begin
                    e.dut = i; e.rdata = er; e.ww = we; e.err = ee; e.cyc = cyc + 2 + wc(i);
                    sbq.push_back(e);
                end
                @(posedge clk);
                #1;
                req_valid[i] = 1'b0;
                req_we[i]    = ~we;
                req_addr[i]  = ~a;
                req_wdata[i] = ~d;
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            req_valid[i] = 1'b0;
            total++;
            bad++;
            $display("FAIL accept_timeout dut=%0d actual=not_accepted required=accepted", i);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !rsp_valid[0] && !rsp_valid[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=pending=%0d required=pending=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic wait_valid(input int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL valid_timeout dut=%0d actual=0 required=1", i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
        end

        // Reset, then idle with req_valid low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("req_ready_in_rst", 32'(req_ready[0]), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("idle_req_ready", 32'(req_ready[i]), 32'd1);
                check("idle_rsp_valid", 32'(rsp_valid[i]), 32'd0);
                check("idle_rsp_rdata", 32'(rsp_rdata[i]), 32'd0);
                check("idle_rsp_err", 32'(rsp_err[i]), 32'd0);
                check("idle_rsp_was_write", 32'(rsp_was_write[i]), 32'd0);
            end
        end

        // Write then read back, WAIT_CYCLES=2.
        issue(0, 1'b1, 12'h010, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
        issue(0, 1'b0, 12'h010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
        drain();

        // Backpressure on a read response.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 12'h010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
        wait_valid(0);
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
            check("bp_rsp_rdata", 32'(rsp_rdata[0]), 32'hBEEF);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_req_ready", 32'(req_ready[0]), 32'd1);
        check("bp_release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp_release_rdata_kept", 32'(rsp_rdata[0]), 32'hBEEF);

        // Out-of-range handling with DEPTH=256.
        issue(0, 1'b1, 12'h000, 16'h1111, 16'h0000, 1'b0, 1'b1);
        issue(0, 1'b1, 12'h0FF, 16'h2222, 16'h0000, 1'b0, 1'b1);
        issue(0, 1'b1, 12'h100, 16'h1234, 16'h0000, 1'b1, 1'b1);
        issue(0, 1'b0, 12'h000, 16'h0000, 16'h1111, 1'b0, 1'b1);
        issue(0, 1'b0, 12'h0FF, 16'h0000, 16'h2222, 1'b0, 1'b1);
        issue(0, 1'b0, 12'h100, 16'h0000, 16'h0000, 1'b1, 1'b1);
        issue(0, 1'b0, 12'hFFF, 16'h0000, 16'h0000, 1'b1, 1'b1);
        drain();

        // Reset one cycle after accepting a write: write abandoned.
        issue(0, 1'b1, 12'h020, 16'h5555, 16'h0000, 1'b0, 1'b1);
        issue(0, 1'b0, 12'h020, 16'h0000, 16'h5555, 1'b0, 1'b1);
        drain();
        issue(0, 1'b1, 12'h020, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_wait_no_rsp", 32'(rsp_valid[0]), 32'd0);
        check("rst_wait_req_ready", 32'(req_ready[0]), 32'd1);
        issue(0, 1'b0, 12'h020, 16'h0000, 16'h5555, 1'b0, 1'b1);
        drain();

        // Reset coinciding with the commit edge: write suppressed.
        issue(0, 1'b1, 12'h020, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_commit_no_rsp", 32'(rsp_valid[0]), 32'd0);
        issue(0, 1'b0, 12'h020, 16'h0000, 16'h5555, 1'b0, 1'b1);
        drain();

        // WAIT_CYCLES=0, full address space, back-to-back pairs.
        for (int k = 0; k < 8; k++) begin
            logic [11:0] a;
            logic [15:0] d;
            a = 12'hFFF - 12'(k * 12'h111);
            d = 16'hC0DE + 16'(k * 16'h0101);
            issue(1, 1'b1, a, d, 16'h0000, 1'b0, 1'b1);
            issue(1, 1'b0, a, 16'h0000, d, 1'b0, 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
